// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack, decoder pipeline register
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_cnt / stall_cnt counters)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] redir_aligned;
  logic [31:0] pc_plus4;

  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4      = pc_q + 32'd4;

  // The request is held low during reset so an abandoned transaction is visibly dropped.
  assign imem_req  = rst_n && (state_q != HOLD);
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_WORD;
      pc_out_q  <= 32'd0;
      valid_q   <= 1'b0;
      hold_ir_q <= 32'd0;
      hold_pc_q <= 32'd0;
      tgt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      hold_ir_q <= hold_ir_d;
      hold_pc_q <= hold_pc_d;
      tgt_q     <= tgt_d;
    end
  end

  // Next-state logic; priority is redirect, then ack, then stall. A flush ignores stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    hold_ir_d = hold_ir_q;
    hold_pc_d = hold_pc_q;
    tgt_d     = tgt_q;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          ir_d    = NOP_WORD;
          if (imem_ack) begin
            pc_d = redir_aligned;
          end else begin
            // Request to the old PC is still outstanding; wait for it and drop it.
            tgt_d   = redir_aligned;
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (!stall) begin
            ir_d     = imem_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end else begin
            hold_ir_d = imem_data;
            hold_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
          ir_d    = NOP_WORD;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          ir_d    = NOP_WORD;
          pc_d    = redir_aligned;
          state_d = FETCH;
        end else if (!stall) begin
          ir_d     = hold_ir_q;
          pc_out_d = hold_pc_q;
          valid_d  = 1'b1;
          state_d  = FETCH;
        end
      end

      DISCARD: begin
        valid_d = 1'b0;
        ir_d    = NOP_WORD;
        if (redirect) begin
          tgt_d = redir_aligned;
        end
        if (imem_ack) begin
          pc_d    = redirect ? redir_aligned : tgt_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Count acks that deliver a usable word, and cycles where a valid word is held by stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if ((state_q == FETCH) && imem_ack && !redirect) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && valid_q) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic a, input logic [31:0] d, input logic s,
                     input logic r, input logic [31:0] rp);
    imem_ack    = a;
    imem_data   = d;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic expect_all(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ir, input logic [31:0] pc);
    check_eq({tag, ".req"},   {31'd0, imem_req},  {31'd0, req});
    check_eq({tag, ".addr"},  imem_addr,          addr);
    check_eq({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vld});
    check_eq({tag, ".ir"},    ir_out,             ir);
    check_eq({tag, ".pc"},    pc_out,             pc);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 32'd0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.req", {31'd0, imem_req}, 32'd0);
    check_eq("rst.valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst.ir", ir_out, NOP);
    check_eq("rst.pc", pc_out, 32'd0);
    rst_n = 1'b1;
    #1;
    expect_all("rel", 1'b1, 32'h1000, 1'b0, NOP, 32'd0);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("idle0", 1'b1, 32'h1000, 1'b0, NOP, 32'd0);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("idle1", 1'b1, 32'h1000, 1'b0, NOP, 32'd0);

    // zero-wait fetches
    cyc(1, 32'h0050_0093, 0, 0, 32'd0);
    expect_all("zw0", 1'b1, 32'h1004, 1'b1, 32'h0050_0093, 32'h1000);
    cyc(1, 32'h00A0_0113, 0, 0, 32'd0);
    expect_all("zw1", 1'b1, 32'h1008, 1'b1, 32'h00A0_0113, 32'h1004);

    // ack while stalled -> HOLD for 3 stalled cycles
    cyc(1, 32'h0020_81B3, 1, 0, 32'd0);
    expect_all("hold0", 1'b0, 32'h100C, 1'b1, 32'h00A0_0113, 32'h1004);
    cyc(0, 32'd0, 1, 0, 32'd0);
    expect_all("hold1", 1'b0, 32'h100C, 1'b1, 32'h00A0_0113, 32'h1004);
    cyc(0, 32'd0, 1, 0, 32'd0);
    expect_all("hold2", 1'b0, 32'h100C, 1'b1, 32'h00A0_0113, 32'h1004);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("unhold", 1'b1, 32'h100C, 1'b1, 32'h0020_81B3, 32'h1008);

    // redirect with request outstanding -> DISCARD, stale data dropped
    cyc(0, 32'd0, 0, 1, 32'h0000_2002);
    expect_all("disc0", 1'b1, 32'h100C, 1'b0, NOP, 32'h1008);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("disc1", 1'b1, 32'h100C, 1'b0, NOP, 32'h1008);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 32'd0);
    expect_all("disc2", 1'b1, 32'h2000, 1'b0, NOP, 32'h1008);

    // latest redirect in DISCARD wins
    cyc(0, 32'd0, 0, 1, 32'h0000_4000);
    cyc(0, 32'd0, 0, 1, 32'h0000_5000);
    expect_all("late0", 1'b1, 32'h2000, 1'b0, NOP, 32'h1008);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 32'd0);
    expect_all("late1", 1'b1, 32'h5000, 1'b0, NOP, 32'h1008);

    // redirect together with ack in DISCARD goes straight to the new target
    cyc(0, 32'd0, 0, 1, 32'h0000_6000);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_7001);
    expect_all("dra", 1'b1, 32'h7000, 1'b0, NOP, 32'h1008);
    cyc(1, 32'h1111_1111, 0, 0, 32'd0);
    expect_all("f7000", 1'b1, 32'h7004, 1'b1, 32'h1111_1111, 32'h7000);

    // ack + stall + redirect in FETCH: redirect wins, flush overrides stall
    cyc(1, 32'hDEAD_BEEF, 1, 1, 32'h0000_3000);
    expect_all("asr", 1'b1, 32'h3000, 1'b0, NOP, 32'h7000);

    // redirect while in HOLD
    cyc(1, 32'hDEAD_BEEF, 1, 0, 32'd0);
    expect_all("hr0", 1'b0, 32'h3004, 1'b0, NOP, 32'h7000);
    cyc(0, 32'd0, 1, 1, 32'h0000_8000);
    expect_all("hr1", 1'b1, 32'h8000, 1'b0, NOP, 32'h7000);

    // stalled without ack keeps output, unstalled without ack is a bubble
    cyc(1, 32'h2222_2222, 0, 0, 32'd0);
    expect_all("sb0", 1'b1, 32'h8004, 1'b1, 32'h2222_2222, 32'h8000);
    cyc(0, 32'd0, 1, 0, 32'd0);
    expect_all("sb1", 1'b1, 32'h8004, 1'b1, 32'h2222_2222, 32'h8000);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("sb2", 1'b1, 32'h8004, 1'b0, NOP, 32'h8000);

    // PC wraps past the top of the address space
    cyc(0, 32'd0, 0, 1, 32'hFFFF_FFFF);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 32'd0);
    expect_all("wr0", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'h8000);
    cyc(1, 32'h3333_3333, 0, 0, 32'd0);
    expect_all("wr1", 1'b1, 32'h0000_0000, 1'b1, 32'h3333_3333, 32'hFFFF_FFFC);

    // mid-operation async reset
    rst_n = 1'b0;
    #1;
    expect_all("mrst", 1'b0, 32'h1000, 1'b0, NOP, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    expect_all("mrel", 1'b1, 32'h1000, 1'b0, NOP, 32'd0);

    // counter scenario: 5 acks (1 dropped by redirect), 2 stalled-valid cycles
    cyc(1, 32'hA000_0001, 0, 0, 32'd0);
    cyc(1, 32'hA000_0002, 1, 0, 32'd0);
    cyc(0, 32'd0, 1, 0, 32'd0);
    cyc(0, 32'd0, 0, 0, 32'd0);
    expect_all("pc0", 1'b1, 32'h1008, 1'b1, 32'hA000_0002, 32'h1004);
    cyc(1, 32'hA000_0003, 0, 0, 32'd0);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_9000);
    cyc(1, 32'hA000_0004, 0, 0, 32'd0);
    expect_all("pc1", 1'b1, 32'h9004, 1'b1, 32'hA000_0004, 32'h9000);
`ifdef FETCH_PERF_CNT_EN
    check_eq("fetch_cnt", fetch_cnt, 32'd4);
    check_eq("stall_cnt", stall_cnt, 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("fetch_cnt.rst", fetch_cnt, 32'd0);
    check_eq("stall_cnt.rst", stall_cnt, 32'd0);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
